// File: rtl/fsx_pkg.sv
// Shared timing arithmetic and pixel types for the FSX timing mixer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fsx_pkg;

   // RGB332 pixel as driven onto the VGA pins
   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
   } rgb332_t;

   // Sync/enable bundle carried through the renderer delay line (pin levels, polarity applied)
   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
   } tsync_t;

   localparam logic [7:0] KEY_DEFAULT = 8'h00;

   // Counter value after which sync asserts
   function automatic int sync_sta(input int fp);
      return fp - 1;
   endfunction

   // Last counter value with sync asserted
   function automatic int sync_end(input int fp, input int sync);
      return sync_sta(fp) + sync;
   endfunction

   // Counter value after which the active area starts
   function automatic int act_sta(input int fp, input int sync, input int bp);
      return sync_end(fp, sync) + bp;
   endfunction

   // Last active counter value; also the wrap point of the counter
   function automatic int act_end(input int fp, input int sync, input int bp, input int res);
      return act_sta(fp, sync, bp) + res;
   endfunction

endpackage

// File: rtl/fsx_timing_mixer_if.sv
// Layer pixel inputs and VGA pin outputs of the timing mixer.
// Latency: n/a (wiring only).
// Backpressure: none; pixels are consumed every clock, pins are free-running.
interface fsx_timing_mixer_if #(
   parameter int LAYERS = 4
);
   logic [7:0]          bg_pix;
   logic [8*LAYERS-1:0] layer_pix;
   logic [LAYERS-1:0]   layer_valid;
   logic [LAYERS-1:0]   layer_behind;
   logic [2:0]          vga_r;
   logic [2:0]          vga_g;
   logic [1:0]          vga_b;
   logic                vga_hs;
   logic                vga_vs;
   logic                vga_blk;

   // master: the mixer, consuming renderer pixels and driving the pins
   modport master (
      input  bg_pix, layer_pix, layer_valid, layer_behind,
      output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blk
   );

   // slave: renderers feeding pixels and the display sampling the pins
   modport slave (
      output bg_pix, layer_pix, layer_valid, layer_behind,
      input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blk
   );
endinterface

// File: rtl/fsx_sync_gen.sv
// h/v counters, raw sync and display enable, active pixel coordinates, frame strobes.
// Latency: counters registered; raw sync/de/o_h/o_v/o_frame combinational from counters; frame_drawn 1 clock.
// Backpressure: none; free-running every clock.
module fsx_sync_gen
   import fsx_pkg::*;
#(
   parameter int H_RES  = 480,
   parameter int V_RES  = 272,
   parameter int H_FP   = 82,
   parameter int H_SYNC = 41,
   parameter int H_BP   = 2,
   parameter int V_FP   = 2,
   parameter int V_SYNC = 10,
   parameter int V_BP   = 2,
   parameter bit H_POL  = 1'b0,
   parameter bit V_POL  = 1'b0,
   parameter int HW     = 10,
   parameter int VW     = 9
) (
   input  logic          vga_clk,
   input  logic          reset,
   output logic [HW-1:0] h_count,
   output logic [VW-1:0] v_count,
   output logic          o_de,
   output logic [HW-1:0] o_h,
   output logic [VW-1:0] o_v,
   output logic          o_frame,
   output tsync_t        raw,
   output logic          frame_drawn
);

   localparam logic [HW-1:0] HS_STA_C = HW'(sync_sta(H_FP));
   localparam logic [HW-1:0] HS_END_C = HW'(sync_end(H_FP, H_SYNC));
   localparam logic [HW-1:0] HA_STA_C = HW'(act_sta(H_FP, H_SYNC, H_BP));
   localparam logic [HW-1:0] HA_END_C = HW'(act_end(H_FP, H_SYNC, H_BP, H_RES));
   localparam logic [HW-1:0] HX0_C    = HW'(act_sta(H_FP, H_SYNC, H_BP) + 1);
   localparam logic [VW-1:0] VS_STA_C = VW'(sync_sta(V_FP));
   localparam logic [VW-1:0] VS_END_C = VW'(sync_end(V_FP, V_SYNC));
   localparam logic [VW-1:0] VA_STA_C = VW'(act_sta(V_FP, V_SYNC, V_BP));
   localparam logic [VW-1:0] VA_END_C = VW'(act_end(V_FP, V_SYNC, V_BP, V_RES));
   localparam logic [VW-1:0] VY0_C    = VW'(act_sta(V_FP, V_SYNC, V_BP) + 1);
   localparam logic [HW-1:0] LINE_C   = HA_END_C;
   localparam logic [VW-1:0] FRAME_C  = VA_END_C;

   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic          frame_drawn_q, frame_drawn_d;
   logic          hs_on, vs_on, h_act, v_act;

   // Next counter state; the end-of-frame interrupt fires off the last counter value of the last active line
   always_comb begin
      h_d           = h_q + HW'(1);
      v_d           = v_q;
      frame_drawn_d = (h_q == LINE_C) && (v_q == VA_END_C);
      if (h_q == LINE_C) begin
         h_d = '0;
         v_d = (v_q == FRAME_C) ? '0 : v_q + VW'(1);
      end
      if (reset) begin
         h_d           = '0;
         v_d           = '0;
         frame_drawn_d = 1'b0;
      end
   end

   // Counter and interrupt registers
   always_ff @(posedge vga_clk) begin
      h_q           <= h_d;
      v_q           <= v_d;
      frame_drawn_q <= frame_drawn_d;
   end

   // Raw sync, enable and coordinates decoded straight from the counters
   always_comb begin
      hs_on   = (h_q > HS_STA_C) && (h_q <= HS_END_C);
      vs_on   = (v_q > VS_STA_C) && (v_q <= VS_END_C);
      h_act   = (h_q > HA_STA_C) && (h_q <= HA_END_C);
      v_act   = (v_q > VA_STA_C) && (v_q <= VA_END_C);
      raw.hs  = hs_on ~^ H_POL;
      raw.vs  = vs_on ~^ V_POL;
      raw.de  = h_act && v_act;
      o_de    = raw.de;
      o_h     = raw.de ? h_q - HX0_C : '0;
      o_v     = raw.de ? v_q - VY0_C : '0;
      o_frame = (h_q == '0) && (v_q == '0);
   end

   assign h_count     = h_q;
   assign v_count     = v_q;
   assign frame_drawn = frame_drawn_q;

endmodule

// File: rtl/fsx_timing_mixer.sv
// Display timing generator plus N-layer priority/key-colour compositor driving registered RGB332 VGA pins.
// Latency: vga_* pins follow the counter value that produced them by PIPE+1 clocks; frame_drawn by 1 clock.
// Backpressure: none; renderers must deliver pixels exactly PIPE clocks after the counters.
module fsx_timing_mixer
   import fsx_pkg::*;
#(
   parameter int         H_RES  = 480,
   parameter int         V_RES  = 272,
   parameter int         H_FP   = 82,
   parameter int         H_SYNC = 41,
   parameter int         H_BP   = 2,
   parameter int         V_FP   = 2,
   parameter int         V_SYNC = 10,
   parameter int         V_BP   = 2,
   parameter bit         H_POL  = 1'b0,
   parameter bit         V_POL  = 1'b0,
   parameter int         LAYERS = 4,
   parameter int         PIPE   = 2,
   parameter logic [7:0] KEY    = KEY_DEFAULT,
   localparam int        HW     = $clog2(act_end(H_FP, H_SYNC, H_BP, H_RES) + 1),
   localparam int        VW     = $clog2(act_end(V_FP, V_SYNC, V_BP, V_RES) + 1)
) (
   input  logic                 vga_clk,
   input  logic                 reset,
   input  logic                 force_blank,
   output logic [HW-1:0]        h_count,
   output logic [VW-1:0]        v_count,
   output logic                 o_de,
   output logic [HW-1:0]        o_h,
   output logic [VW-1:0]        o_v,
   output logic                 o_frame,
   output logic                 frame_drawn,
   fsx_timing_mixer_if.master   pix_if
);

   // One delay-line slot even when PIPE is 0 keeps the array legal; it is bypassed then
   localparam int     DW   = (PIPE > 0) ? PIPE : 1;
   localparam tsync_t IDLE = '{hs: ~H_POL, vs: ~V_POL, de: 1'b0};

   tsync_t          raw, stg;
   tsync_t [DW-1:0] dly_q, dly_d;
   rgb332_t         mix, rgb_q, rgb_d;
   logic            hs_q, hs_d, vs_q, vs_d, blk_q, blk_d;
   logic            fg_hit, bk_hit;
   logic [7:0]      fg_pix, bk_pix;

   fsx_sync_gen #(
      .H_RES(H_RES), .V_RES(V_RES), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .H_POL(H_POL), .V_POL(V_POL),
      .HW(HW), .VW(VW)
   ) u_sync (
      .vga_clk     (vga_clk),
      .reset       (reset),
      .h_count     (h_count),
      .v_count     (v_count),
      .o_de        (o_de),
      .o_h         (o_h),
      .o_v         (o_v),
      .o_frame     (o_frame),
      .raw         (raw),
      .frame_drawn (frame_drawn)
   );

   // Shift raw sync/de along so they line up with the renderers' returned pixels
   always_comb begin
      dly_d    = dly_q;
      dly_d[0] = raw;
      for (int i = 1; i < DW; i++) begin
         dly_d[i] = dly_q[i-1];
      end
      if (reset) begin
         dly_d = {DW{IDLE}};
      end
   end

   // Delay-line registers
   always_ff @(posedge vga_clk) begin
      dly_q <= dly_d;
   end

   assign stg = (PIPE == 0) ? raw : dly_q[DW-1];

   // Priority compose: front layers, then a non-key background, then behind layers, then background
   always_comb begin
      fg_hit = 1'b0;
      fg_pix = '0;
      bk_hit = 1'b0;
      bk_pix = '0;
      for (int i = 0; i < LAYERS; i++) begin
         if (pix_if.layer_valid[i] && !pix_if.layer_behind[i]) begin
            fg_hit = 1'b1;
            fg_pix = pix_if.layer_pix[8*i +: 8];
         end
         if (pix_if.layer_valid[i] && pix_if.layer_behind[i]) begin
            bk_hit = 1'b1;
            bk_pix = pix_if.layer_pix[8*i +: 8];
         end
      end
      if (fg_hit) begin
         mix = rgb332_t'(fg_pix);
      end else if (pix_if.bg_pix != KEY) begin
         mix = rgb332_t'(pix_if.bg_pix);
      end else if (bk_hit) begin
         mix = rgb332_t'(bk_pix);
      end else begin
         mix = rgb332_t'(pix_if.bg_pix);
      end
   end

   // Output stage; force_blank acts here directly so it takes effect on the very next pin update
   always_comb begin
      rgb_d = (stg.de && !force_blank) ? mix : '0;
      hs_d  = stg.hs;
      vs_d  = stg.vs;
      blk_d = stg.de;
      if (reset) begin
         rgb_d = '0;
         hs_d  = ~H_POL;
         vs_d  = ~V_POL;
         blk_d = 1'b0;
      end
   end

   // Pin registers
   always_ff @(posedge vga_clk) begin
      rgb_q <= rgb_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      blk_q <= blk_d;
   end

   assign pix_if.vga_r   = rgb_q.r;
   assign pix_if.vga_g   = rgb_q.g;
   assign pix_if.vga_b   = rgb_q.b;
   assign pix_if.vga_hs  = hs_q;
   assign pix_if.vga_vs  = vs_q;
   assign pix_if.vga_blk = blk_q;

endmodule

// File: tb/tb_fsx_timing_mixer.sv
// Bench for fsx_timing_mixer: full horizontal timing, shortened frame height to keep runs short.
// Latency: n/a.
// Backpressure: n/a.
module tb_fsx_timing_mixer;

   localparam int         H_RES  = 480;
   localparam int         H_FP   = 82;
   localparam int         H_SYNC = 41;
   localparam int         H_BP   = 2;
   localparam int         V_RES  = 8;
   localparam int         V_FP   = 2;
   localparam int         V_SYNC = 2;
   localparam int         V_BP   = 2;
   localparam int         LAYERS = 4;
   localparam int         PIPE   = 2;
   localparam logic [7:0] KEY    = 8'h00;

   // Clocks per line and lines per frame; first active h / v
   localparam int HT  = H_FP + H_SYNC + H_BP + H_RES;   // 605
   localparam int VT  = V_FP + V_SYNC + V_BP + V_RES;   // 14
   localparam int HA0 = H_FP + H_SYNC + H_BP;           // 125
   localparam int VA0 = V_FP + V_SYNC + V_BP;           // 6
   localparam int HW  = $clog2(HT);
   localparam int VW  = $clog2(VT);

   typedef struct packed {
      logic [HW-1:0] h;
      logic [VW-1:0] v;
      logic          de;
      logic [HW-1:0] x;
      logic [VW-1:0] y;
      logic          frame;
   } tim_t;

   typedef struct packed {
      logic [7:0] rgb;
      logic       hs;
      logic       vs;
      logic       blk;
      logic       fd;
   } pin_t;

   typedef struct {
      logic [7:0]          bg;
      logic [8*LAYERS-1:0] pix;
      logic [LAYERS-1:0]   vld;
      logic [LAYERS-1:0]   beh;
      logic                fb;
      logic [7:0]          exp;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          force_blank = 1'b0;
   logic [HW-1:0] h_count;
   logic [VW-1:0] v_count;
   logic          o_de;
   logic [HW-1:0] o_h;
   logic [VW-1:0] o_v;
   logic          o_frame;
   logic          frame_drawn;

   fsx_timing_mixer_if #(.LAYERS(LAYERS)) bus ();

   fsx_timing_mixer #(
      .H_RES(H_RES), .V_RES(V_RES), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .H_POL(1'b0), .V_POL(1'b0),
      .LAYERS(LAYERS), .PIPE(PIPE), .KEY(KEY)
   ) dut (
      .vga_clk     (clk),
      .reset       (reset),
      .force_blank (force_blank),
      .h_count     (h_count),
      .v_count     (v_count),
      .o_de        (o_de),
      .o_h         (o_h),
      .o_v         (o_v),
      .o_frame     (o_frame),
      .frame_drawn (frame_drawn),
      .pix_if      (bus)
   );

   always #5 clk = ~clk;

   int   cyc;          // rising edges since reset was last applied
   int   n_cmp = 0;
   int   n_bad = 0;
   int   hs_lo_cnt, hs_first, blk_cnt, fd_cnt, fd_last;
   vec_t tbl [14];

   // Where the counters stand after c edges since reset
   function automatic tim_t model_tim(input int c);
      tim_t t;
      int h, v;
      h       = c % HT;
      v       = (c / HT) % VT;
      t.h     = HW'(h);
      t.v     = VW'(v);
      t.de    = (h >= HA0) && (h < HA0 + H_RES) && (v >= VA0) && (v < VA0 + V_RES);
      t.x     = t.de ? HW'(h - HA0) : '0;
      t.y     = t.de ? VW'(v - VA0) : '0;
      t.frame = (h == 0) && (v == 0);
      return t;
   endfunction

   // Winning pixel: top-down search of front layers, background, behind layers
   function automatic logic [7:0] model_mix(input logic [7:0] bg, input logic [8*LAYERS-1:0] pix,
                                            input logic [LAYERS-1:0] vld, input logic [LAYERS-1:0] beh);
      logic [7:0] res;
      logic       found;
      found = 1'b0;
      res   = bg;
      for (int i = LAYERS - 1; i >= 0; i--) begin
         if (!found && vld[i] && !beh[i]) begin
            found = 1'b1;
            res   = pix[8*i +: 8];
         end
      end
      if (!found && bg != KEY) found = 1'b1;
      for (int i = LAYERS - 1; i >= 0; i--) begin
         if (!found && vld[i] && beh[i]) begin
            found = 1'b1;
            res   = pix[8*i +: 8];
         end
      end
      return res;
   endfunction

   // Pins seen after edge c: counter value c-(PIPE+1), pixel inputs present at edge c
   function automatic pin_t model_pins(input int c);
      pin_t p;
      tim_t t;
      int   src;
      src   = c - (PIPE + 1);
      p.hs  = 1'b1;
      p.vs  = 1'b1;
      p.blk = 1'b0;
      p.rgb = '0;
      if (src >= 0) begin
         t     = model_tim(src);
         p.hs  = !((int'(t.h) >= H_FP) && (int'(t.h) < H_FP + H_SYNC));
         p.vs  = !((int'(t.v) >= V_FP) && (int'(t.v) < V_FP + V_SYNC));
         p.blk = t.de;
         if (t.de && !force_blank)
            p.rgb = model_mix(bus.bg_pix, bus.layer_pix, bus.layer_valid, bus.layer_behind);
      end
      p.fd = 1'b0;
      if (c >= 1) begin
         t    = model_tim(c - 1);
         p.fd = (int'(t.h) == HT - 1) && (int'(t.v) == VT - 1);
      end
      return p;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   // One clock: inputs stay put across the edge, outputs checked at the falling edge
   task automatic tick();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check("timing", {h_count, v_count, o_de, o_h, o_v, o_frame}, model_tim(cyc));
      check("pins", {bus.vga_r, bus.vga_g, bus.vga_b, bus.vga_hs, bus.vga_vs, bus.vga_blk, frame_drawn},
            model_pins(cyc));
      if (bus.vga_hs == 1'b0) begin
         hs_lo_cnt++;
         if (hs_first < 0) hs_first = cyc;
      end
      if (bus.vga_blk) blk_cnt++;
      if (frame_drawn) begin
         fd_cnt++;
         fd_last = cyc;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cyc    = 0;
      fd_cnt = 0;
      check("rst_h", h_count, '0);
      check("rst_v", v_count, '0);
      check("rst_sync", {bus.vga_hs, bus.vga_vs}, 2'b11);
      check("rst_blk_rgb", {bus.vga_blk, bus.vga_r, bus.vga_g, bus.vga_b}, '0);
      check("rst_fd", frame_drawn, 1'b0);
      reset = 1'b0;
   endtask

   initial begin
      int guard;
      cyc = 0;
      bus.bg_pix       = '0;
      bus.layer_pix    = '0;
      bus.layer_valid  = '0;
      bus.layer_behind = '0;
      tbl[0]  = '{8'h1C, 32'h0300E000, 4'b1010, 4'b0000, 1'b0, 8'h03};
      tbl[1]  = '{8'h1C, 32'h0300E000, 4'b1010, 4'b1000, 1'b0, 8'hE0};
      tbl[2]  = '{8'h00, 32'h00FF0000, 4'b0100, 4'b0100, 1'b0, 8'hFF};
      tbl[3]  = '{8'h1C, 32'h00FF0000, 4'b0100, 4'b0100, 1'b0, 8'h1C};
      tbl[4]  = '{8'h00, 32'h00000000, 4'b0000, 4'b0000, 1'b0, 8'h00};
      tbl[5]  = '{8'h55, 32'hFFFFFFFF, 4'b0000, 4'b0000, 1'b0, 8'h55};
      tbl[6]  = '{8'h1C, 32'h00000012, 4'b0001, 4'b0000, 1'b0, 8'h12};
      tbl[7]  = '{8'h1C, 32'h44332211, 4'b1111, 4'b0000, 1'b0, 8'h44};
      tbl[8]  = '{8'h1C, 32'h0300E000, 4'b1010, 4'b0000, 1'b1, 8'h00};
      tbl[9]  = '{8'h00, 32'h00004221, 4'b0011, 4'b0011, 1'b0, 8'h42};
      tbl[10] = '{8'h00, 32'h81000007, 4'b1001, 4'b1000, 1'b0, 8'h07};
      tbl[11] = '{8'h1C, 32'hFF000000, 4'b0000, 4'b0000, 1'b0, 8'h1C};
      tbl[12] = '{8'h00, 32'h81000007, 4'b1001, 4'b1001, 1'b0, 8'h81};
      tbl[13] = '{8'h2A, 32'h81000007, 4'b1001, 4'b1001, 1'b0, 8'h2A};

      repeat (3) @(posedge clk);
      @(negedge clk);
      do_reset();

      // First line: hs low for H_SYNC clocks starting PIPE+1 after h==H_FP, no active pixels
      hs_lo_cnt = 0; hs_first = -1; blk_cnt = 0;
      repeat (HT) tick();
      check("hs_width", hs_lo_cnt, H_SYNC);
      check("hs_first", hs_first, H_FP + PIPE + 1);
      check("blk_blank_line", blk_cnt, 0);

      // A full active line seen at the pins
      while (cyc < VA0 * HT + PIPE) tick();
      blk_cnt = 0;
      repeat (HT) tick();
      check("blk_line", blk_cnt, H_RES);

      // Compose vectors, each applied on a clock whose delayed enable is active
      foreach (tbl[k]) begin
         guard = 0;
         while (!(cyc >= PIPE && model_tim(cyc - PIPE).de) && guard < 2 * HT) begin
            tick();
            guard++;
         end
         bus.bg_pix       = tbl[k].bg;
         bus.layer_pix    = tbl[k].pix;
         bus.layer_valid  = tbl[k].vld;
         bus.layer_behind = tbl[k].beh;
         force_blank      = tbl[k].fb;
         tick();
         check($sformatf("tbl%0d", k), {bus.vga_r, bus.vga_g, bus.vga_b}, tbl[k].exp);
      end
      force_blank = 1'b0;

      // Random pixels across two frame ends
      while (cyc < 2 * VT * HT + 100) begin
         bus.bg_pix       = ($urandom_range(0, 3) == 0) ? KEY : 8'($urandom);
         bus.layer_pix    = 32'($urandom);
         bus.layer_valid  = 4'($urandom);
         bus.layer_behind = 4'($urandom);
         force_blank      = ($urandom_range(0, 15) == 0);
         tick();
      end
      check("fd_count", fd_cnt, 2);
      check("fd_pos", fd_last, 2 * VT * HT);
      force_blank = 1'b0;

      // Reset in the middle of an active line, then one full clean frame
      guard = 0;
      while (!(model_tim(cyc).v == VW'(7) && model_tim(cyc).h == HW'(300)) && guard < 2 * VT * HT) begin
         tick();
         guard++;
      end
      check("midframe_reached", guard < 2 * VT * HT, 1'b1);
      bus.bg_pix      = 8'h1C;
      bus.layer_valid = '0;
      do_reset();
      repeat (VT * HT - 1) tick();
      check("fd_none_after_reset", fd_cnt, 0);
      tick();
      check("fd_after_reset", fd_cnt, 1);
      check("fd_after_reset_pos", fd_last, VT * HT);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
